// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shared memory port sequencer/arbiter for fetch and data stages
// Optional ARB_RR_EN selects round-robin arbitration; default is fixed data-first priority.
module mem_arbiter #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              stall_if,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              stall_dm,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // WAIT runs LATENCY-1 cycles after ISSUE; the last one has cnt == 0
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;   // 1 = data port, 0 = fetch
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              dm_req, grant_dm, capture;
`ifdef ARB_RR_EN
  logic              last_grant_q, last_grant_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    capture    = 1'b0;
    dm_req     = dm_rd | dm_wr;
`ifdef ARB_RR_EN
    last_grant_d = last_grant_q;
    grant_dm     = dm_req & (~if_req | ~last_grant_q);
`else
    grant_dm     = dm_req;
`endif
    case (state_q)
      IDLE: begin
        if (if_req | dm_req) begin
          state_d = ISSUE;
          owner_d = grant_dm;
          addr_d  = grant_dm ? dm_addr : if_addr;
          wr_d    = grant_dm & dm_wr & ~dm_rd;
          if (grant_dm) wdata_d = dm_wdata;
`ifdef ARB_RR_EN
          last_grant_d = grant_dm;
`endif
        end
      end
      ISSUE: begin
        if (LATENCY == 1) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (capture && !wr_q) begin
      if (owner_q) dm_rdata_d = mem_rdata;
      else         if_rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      owner_q    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk) begin
    if (!rst) last_grant_q <= 1'b0;
    else      last_grant_q <= last_grant_d;
  end
`endif

  assign mem_enable = (state_q == ISSUE);
  assign mem_wr     = mem_enable & wr_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign if_done    = (state_q == RESP) & ~owner_q;
  assign dm_done    = (state_q == RESP) & owner_q;
  assign if_rdata   = if_rdata_q;
  assign dm_rdata   = dm_rdata_q;
  assign stall_if   = if_req & ~if_done;
  assign stall_dm   = (dm_rd | dm_wr) & ~dm_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized bench for mem_arbiter at LATENCY 4 and 1 against a transaction-level model
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic if_req, dm_rd, dm_wr;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [1:0] if_done_o, dm_done_o, stall_if_o, stall_dm_o, mem_en_o, mem_wr_o;
  logic [1:0][15:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.LATENCY((g == 0) ? 4 : 1), .ADDR_W(16), .DATA_W(16)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done_o[g]),
      .if_rdata(if_rdata_o[g]), .stall_if(stall_if_o[g]),
      .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_done(dm_done_o[g]), .dm_rdata(dm_rdata_o[g]), .stall_dm(stall_dm_o[g]),
      .mem_enable(mem_en_o[g]), .mem_wr(mem_wr_o[g]), .mem_addr(mem_addr_o[g]),
      .mem_wdata(mem_wdata_o[g]), .mem_rdata(mem_rdata)
    );
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // transaction model: one access in flight, located by the cycle it issued
  int          lat [2] = '{4, 1};
  bit          busy [2];
  int          t_iss [2];
  bit          own [2];
  bit          mwr [2];
  bit          lastg [2];
  logic [15:0] maddr [2], mwd [2], erd_if [2], erd_dm [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    bit dreq, gdm;
    int ph;
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        busy[k] = 0; lastg[k] = 0; maddr[k] = '0; mwd[k] = '0;
        erd_if[k] = '0; erd_dm[k] = '0; own[k] = 0; mwr[k] = 0;
      end else if (!busy[k]) begin
        dreq = dm_rd | dm_wr;
        if (if_req || dreq) begin
`ifdef ARB_RR_EN
          gdm = dreq && (!if_req || !lastg[k]);
`else
          gdm = dreq;
`endif
          busy[k]  = 1;
          t_iss[k] = cyc + 1;
          own[k]   = gdm;
          lastg[k] = gdm;
          maddr[k] = gdm ? dm_addr : if_addr;
          mwr[k]   = gdm && dm_wr && !dm_rd;
          if (gdm) mwd[k] = dm_wdata;
        end
      end else begin
        ph = cyc - t_iss[k];
        if (ph == lat[k] - 1 && !mwr[k]) begin
          if (own[k]) erd_dm[k] = mem_rdata;
          else        erd_if[k] = mem_rdata;
        end
        if (ph == lat[k]) busy[k] = 0;
      end
    end
  endtask

  task automatic check_outputs();
    int ph;
    bit e_en, e_ifd, e_dmd;
    for (int k = 0; k < 2; k++) begin
      ph    = cyc - t_iss[k];
      e_en  = busy[k] && ph == 0;
      e_ifd = busy[k] && ph == lat[k] && !own[k];
      e_dmd = busy[k] && ph == lat[k] && own[k];
      check($sformatf("L%0d.mem_enable", lat[k]), 32'(mem_en_o[k]), 32'(e_en));
      check($sformatf("L%0d.mem_wr", lat[k]), 32'(mem_wr_o[k]), 32'(e_en && mwr[k]));
      check($sformatf("L%0d.mem_addr", lat[k]), 32'(mem_addr_o[k]), 32'(maddr[k]));
      check($sformatf("L%0d.mem_wdata", lat[k]), 32'(mem_wdata_o[k]), 32'(mwd[k]));
      check($sformatf("L%0d.if_done", lat[k]), 32'(if_done_o[k]), 32'(e_ifd));
      check($sformatf("L%0d.dm_done", lat[k]), 32'(dm_done_o[k]), 32'(e_dmd));
      check($sformatf("L%0d.if_rdata", lat[k]), 32'(if_rdata_o[k]), 32'(erd_if[k]));
      check($sformatf("L%0d.dm_rdata", lat[k]), 32'(dm_rdata_o[k]), 32'(erd_dm[k]));
      check($sformatf("L%0d.stall_if", lat[k]), 32'(stall_if_o[k]), 32'(if_req && !e_ifd));
      check($sformatf("L%0d.stall_dm", lat[k]), 32'(stall_dm_o[k]), 32'((dm_rd || dm_wr) && !e_dmd));
    end
  endtask

  initial begin
    rst = 1'b0; if_req = 1'b1; dm_rd = 1'b0; dm_wr = 1'b1;
    if_addr = 16'h0010; dm_addr = 16'h0100; dm_wdata = 16'h1234; mem_rdata = 16'hBEEF;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
      if (i < 2)        rst = 1'b0;
      else if (i < 150) rst = 1'b1;
      else              rst = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 3) == 0) if_req = ~if_req;
      if ($urandom_range(0, 4) == 0) dm_rd  = ~dm_rd;
      if ($urandom_range(0, 4) == 0) dm_wr  = ~dm_wr;
      if_addr   = 16'($urandom);
      dm_addr   = 16'($urandom);
      dm_wdata  = 16'($urandom);
      mem_rdata = 16'($urandom);
      @(negedge clk);
      check_outputs();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Multi-cycle sequencer and arbiter that shares one backing memory port between instruction fetch and data memory stage.
- Latches one request at a time, drives memory enable/wr/addr/wdata for one issue cycle, waits a fixed latency, captures read data, pulses per-requester done.
- Generates per-requester stall for the pipeline hazard logic.
- Sits between fetch/memory stages and the memory model.

Parameters:
- LATENCY, 4, cycles from ISSUE cycle to memory read data valid, counted inclusively. Legal range 1..15. Value 1 means read data is valid in the ISSUE cycle itself.
- ADDR_W, 16, address width.
- DATA_W, 16, data width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- if_req  input  1  fetch read request, level, held until if_done.
- if_addr  input  ADDR_W  fetch address.
- if_done  output  1  one-cycle pulse, fetch access complete.
- if_rdata  output  DATA_W  fetch read data, registered.
- stall_if  output  1  if_req & ~if_done.
- dm_rd  input  1  data read request, level.
- dm_wr  input  1  data write request, level.
- dm_addr  input  ADDR_W  data address.
- dm_wdata  input  DATA_W  data write value.
- dm_done  output  1  one-cycle pulse, data access complete.
- dm_rdata  output  DATA_W  data read result, registered.
- stall_dm  output  1  (dm_rd|dm_wr) & ~dm_done.
- mem_enable  output  1  memory access strobe, high only in ISSUE.
- mem_wr  output  1  1 = write, valid with mem_enable.
- mem_addr  output  ADDR_W  latched address.
- mem_wdata  output  DATA_W  latched write data.
- mem_rdata  input  DATA_W  memory read data.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. Down-counter cnt (4 bits). Latches: owner, addr, wdata, wr.
- Reset (rst=0 at edge) sets:
  - state IDLE; cnt 0.
  - if_done, dm_done, mem_enable, mem_wr: 0.
  - if_rdata, dm_rdata, mem_addr, mem_wdata: 0.
  - Any in-flight access is abandoned; no done pulse is issued for it.
- IDLE:
  - Any request sampled at the edge: latch owner/addr/wdata/wr, go to ISSUE.
  - No request: stay in IDLE.
- Priority (macro off): the data port always wins over fetch.
- dm_rd and dm_wr both high: treated as a read (wr=0).
- ISSUE:
  - mem_enable=1, mem_wr=latched wr, mem_addr/mem_wdata from latches.
  - LATENCY=1: capture mem_rdata into the owner's rdata at the edge, go to RESP.
  - Otherwise: cnt<=LATENCY-2, go to WAIT.
- WAIT:
  - mem_enable=0; mem_addr/mem_wdata hold their values.
  - cnt==0: capture mem_rdata into the owner's rdata, go to RESP.
  - Otherwise: decrement cnt.
- Write accesses: no capture; the owner's rdata holds its previous value.
- RESP: owner's done=1 for exactly this cycle; next state IDLE.
- Timing: request first sampled in IDLE cycle 0 → ISSUE cycle 1 → done in cycle LATENCY+1. Throughput is one access per LATENCY+2 cycles. There is no issue in the RESP cycle.
- Request inputs changing after latch are ignored until the next IDLE.
- Request dropped mid-access: the access still completes and done still pulses.
- The non-owner's done stays 0 throughout. The non-owner's request stays pending, and its stall stays high.
- stall_if and stall_dm are combinational and deassert in the RESP cycle.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin arbitration.
  - last_grant register, reset to fetch.
  - When both ports request in IDLE, grant goes to the port not granted last.
  - A single requester is always granted; last_grant updates on every grant.
- Undefined: fixed priority, data port first; no last_grant register.

Test Plan:
- Reset: hold rst=0 for 2 cycles with if_req=1, dm_wr=1 → all outputs 0, mem_enable never 1. After release, a request is accepted in the next IDLE.
- Fetch read, LATENCY=4: if_req at cycle 0, if_addr=0x0010; memory returns 0xBEEF in cycle 4 → mem_enable=1, mem_wr=0, mem_addr=0x0010 in cycle 1; if_done=1 and if_rdata=0xBEEF in cycle 5; stall_if=1 in cycles 0-4.
- Data write: dm_wr, dm_addr=0x0100, dm_wdata=0x1234 → cycle 1 has mem_wr=1, mem_wdata=0x1234; dm_done in cycle 5; dm_rdata unchanged.
- Contention, macro off: if_req and dm_rd at cycle 0 → dm_done cycle 5, fetch ISSUE cycle 7, if_done cycle 11. Repeat contention → data wins again.
  - Macro on: repeated contention → second round serves fetch first.
- dm_rd=dm_wr=1 at LATENCY=1, mem_rdata=0x00AA → mem_wr=0, dm_done cycle 2, dm_rdata=0x00AA.
- Reset asserted in WAIT (cycle 3) → no done pulse, state IDLE. A following fetch completes with normal timing.
